// File: rtl/board_step_ctrl.sv
// Board single-step / free-run controller for a soft CPU.
// Push-buttons are synchronised and debounced. A small FSM turns key presses,
// the load switch and a run-rate divider into CPU clock-enable and PC-load strobes.

// One push-button: 2-flop synchroniser, consecutive-cycle debouncer, press pulse.
module board_key_deb #(
  parameter int DEB_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press
);
  localparam int DBW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DBW-1:0] DEB_LAST = DBW'(DEB_CYCLES - 1);

  logic           r_s1, r_s2, r_lvl, r_lvl_d, r_press;
  logic [DBW-1:0] r_cnt;
  logic           w_pressed;

  assign w_pressed = ~r_s2;

  // Synchroniser resets to the released (high) raw level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_key_n;
      r_s2 <= r_s1;
    end
  end

  // Accept a new level only after DEB_CYCLES consecutive differing cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lvl <= 1'b0;
      r_cnt <= '0;
    end else if (w_pressed != r_lvl) begin
      if (r_cnt == DEB_LAST) begin
        r_lvl <= ~r_lvl;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  // Press pulse appears the cycle after the level rises; releases are silent.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lvl_d <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_lvl_d <= r_lvl;
      r_press <= r_lvl & ~r_lvl_d;
    end
  end

  assign o_level = r_lvl;
  assign o_press = r_press;
endmodule

module board_step_ctrl #(
  parameter int N_KEYS     = 4,
  parameter int DEB_CYCLES = 16,
  parameter int DIV_W      = 26,
  parameter int CNT_W      = 16
) (
  input  logic              SYS_clk,
  input  logic              SYS_rst,
  input  logic [N_KEYS-1:0] keys_n,
  input  logic [DIV_W-1:0]  run_div,
  input  logic              load_req,
  output logic              cpu_ce,
  output logic              pc_load,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic              run_mode,
  output logic [CNT_W-1:0]  step_cnt
);
  typedef enum logic [1:0] {ST_STEP, ST_RUN, ST_LOAD} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_ld_s1, r_ld_s2, r_ld_d;
  logic               r_step_ce, w_step_ce_nxt;
  logic [DIV_W-1:0]   r_div, w_div_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_ld_rise, w_div_hit, w_ce, w_pcl;

  // Per-key debouncers.
  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    board_key_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .i_clk   (SYS_clk),
      .i_rst_n (SYS_rst),
      .i_key_n (keys_n[g]),
      .o_level (key_level[g]),
      .o_press (key_press[g])
    );
  end

  // Load switch: synchronise, then keep one more stage for rising-edge detect.
  always_ff @(posedge SYS_clk or negedge SYS_rst) begin
    if (!SYS_rst) begin
      r_ld_s1 <= 1'b0;
      r_ld_s2 <= 1'b0;
      r_ld_d  <= 1'b0;
    end else begin
      r_ld_s1 <= load_req;
      r_ld_s2 <= r_ld_s1;
      r_ld_d  <= r_ld_s2;
    end
  end

  assign w_ld_rise = r_ld_s2 & ~r_ld_d;
  // >= rather than == so a run_div lowered below the count wraps at once.
  assign w_div_hit = (r_div >= run_div);

  // State, divider and pending single-step enable registers.
  always_ff @(posedge SYS_clk or negedge SYS_rst) begin
    if (!SYS_rst) begin
      r_state   <= ST_STEP;
      r_div     <= '0;
      r_step_ce <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_step_ce <= w_step_ce_nxt;
    end
  end

  // Next state and strobes; load edge beats key presses, mode key beats step key.
  always_comb begin
    w_state_nxt   = r_state;
    w_div_nxt     = '0;
    w_step_ce_nxt = 1'b0;
    w_ce          = 1'b0;
    w_pcl         = 1'b0;
    case (r_state)
      ST_STEP: begin
        w_ce = r_step_ce;
        if (w_ld_rise)         w_state_nxt = ST_LOAD;
        else if (key_press[1]) w_state_nxt = ST_RUN;
        else if (key_press[0]) w_step_ce_nxt = 1'b1;
      end
      ST_RUN: begin
        if (w_ld_rise)         w_state_nxt = ST_LOAD;
        else if (key_press[1]) w_state_nxt = ST_STEP;
        else begin
          w_ce      = w_div_hit;
          w_div_nxt = w_div_hit ? '0 : r_div + DIV_W'(1);
        end
      end
      ST_LOAD: begin
        w_pcl       = 1'b1;
        w_state_nxt = ST_STEP;
      end
      default: w_state_nxt = ST_STEP;
    endcase
  end

  // Executed-step counter, cleared by a PC load.
  always_ff @(posedge SYS_clk or negedge SYS_rst) begin
    if (!SYS_rst)  r_cnt <= '0;
    else if (w_pcl) r_cnt <= '0;
    else if (w_ce)  r_cnt <= r_cnt + 1'b1;
  end

  assign cpu_ce   = w_ce;
  assign pc_load  = w_pcl;
  assign run_mode = (r_state == ST_RUN);
  assign step_cnt = r_cnt;
endmodule

// File: tb/tb_board_step_ctrl.sv
// Bench for board_step_ctrl: directed scenarios plus random key/load/divider
// activity, every cycle compared against a rule-level reference model.
module tb_board_step_ctrl;
  localparam int N   = 4;
  localparam int DEB = 16;
  localparam int DW  = 8;
  localparam int CW  = 4;

  logic          SYS_clk = 1'b0;
  logic          SYS_rst;
  logic [N-1:0]  keys_n;
  logic [DW-1:0] run_div;
  logic          load_req;
  logic          cpu_ce, pc_load, run_mode;
  logic [N-1:0]  key_level, key_press;
  logic [CW-1:0] step_cnt;

  int errors = 0;
  int checks = 0;

  board_step_ctrl #(.N_KEYS(N), .DEB_CYCLES(DEB), .DIV_W(DW), .CNT_W(CW)) dut (
    .SYS_clk   (SYS_clk),
    .SYS_rst   (SYS_rst),
    .keys_n    (keys_n),
    .run_div   (run_div),
    .load_req  (load_req),
    .cpu_ce    (cpu_ce),
    .pc_load   (pc_load),
    .key_level (key_level),
    .key_press (key_press),
    .run_mode  (run_mode),
    .step_cnt  (step_cnt)
  );

  always #5 SYS_clk = ~SYS_clk;

  // Reference model. Mode: 0 = STEP, 1 = RUN, 2 = LOAD.
  logic [N-1:0] m_s1, m_s2, m_lvl, m_lvl_d, m_press;
  int           m_cnt [N];
  int           m_mode, m_div, m_steps;
  logic         m_pend, m_l1, m_l2, m_l3;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvl_d = '0; m_press = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_mode = 0; m_div = 0; m_steps = 0; m_pend = 1'b0;
    m_l1 = 1'b0; m_l2 = 1'b0; m_l3 = 1'b0;
  endtask

  function automatic logic ld_edge();
    return m_l2 & ~m_l3;
  endfunction

  function automatic logic exp_ce();
    if (m_mode == 0) return m_pend;
    if (m_mode == 1) return (m_div >= int'(run_div)) && !m_press[1] && !ld_edge();
    return 1'b0;
  endfunction

  task automatic model_step();
    logic         ce, ld;
    logic [N-1:0] np;
    if (!SYS_rst) begin
      model_reset();
      return;
    end
    ce = exp_ce();
    ld = ld_edge();
    if (m_mode == 2)  m_steps = 0;
    else if (ce)      m_steps = (m_steps + 1) % (1 << CW);
    m_pend = (m_mode == 0) && m_press[0] && !m_press[1] && !ld;
    if (m_mode == 1 && !ld && !m_press[1]) m_div = (m_div >= int'(run_div)) ? 0 : m_div + 1;
    else                                   m_div = 0;
    case (m_mode)
      0:       m_mode = ld ? 2 : (m_press[1] ? 1 : 0);
      1:       m_mode = ld ? 2 : (m_press[1] ? 0 : 1);
      default: m_mode = 0;
    endcase
    np      = m_lvl & ~m_lvl_d;
    m_lvl_d = m_lvl;
    for (int i = 0; i < N; i++) begin
      if (m_s2[i] != m_lvl[i]) begin
        m_cnt[i]++;
        if (m_cnt[i] == DEB) begin
          m_lvl[i] = ~m_lvl[i];
          m_cnt[i] = 0;
        end
      end else begin
        m_cnt[i] = 0;
      end
    end
    m_press = np;
    m_s2 = m_s1;
    m_s1 = ~keys_n;
    m_l3 = m_l2; m_l2 = m_l1; m_l1 = load_req;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("cpu_ce",    32'(cpu_ce),    32'(exp_ce()));
    chk("pc_load",   32'(pc_load),   32'(m_mode == 2));
    chk("run_mode",  32'(run_mode),  32'(m_mode == 1));
    chk("key_level", 32'(key_level), 32'(m_lvl));
    chk("key_press", 32'(key_press), 32'(m_press));
    chk("step_cnt",  32'(step_cnt),  32'(m_steps));
  endtask

  task automatic tick();
    @(posedge SYS_clk);
    model_step();
    @(negedge SYS_clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic press(input int k, input int hold, input int gap);
    keys_n[k] = 1'b0;
    ticks(hold);
    keys_n[k] = 1'b1;
    ticks(gap);
  endtask

  int found;

  initial begin
    keys_n   = '1;
    run_div  = 8'd3;
    load_req = 1'b0;
    SYS_rst  = 1'b0;
    model_reset();
    #1;
    check_all();
    ticks(3);
    SYS_rst = 1'b1;
    ticks(2);

    // Glitch of 10 cycles is rejected; stable press accepted 18 cycles later.
    keys_n[0] = 1'b0; ticks(10);
    keys_n[0] = 1'b1; ticks(4);
    chk("glitch_level", 32'(key_level[0]), 32'(0));
    keys_n[0] = 1'b0;
    found = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (key_level[0] && found < 0) found = k;
    end
    chk("deb_latency", 32'(found), 32'(18));
    chk("first_step", 32'(step_cnt), 32'(1));
    keys_n[0] = 1'b1;
    ticks(25);

    // Sixteen more step presses: 4-bit counter wraps past 15.
    for (int p = 0; p < 16; p++)
      press(0, $urandom_range(DEB + 8, DEB + 2), $urandom_range(DEB + 8, DEB + 3));
    chk("step_wrap", 32'(step_cnt), 32'(1));

    // Run mode at run_div=3, then back to STEP.
    run_div = 8'd3;
    press(1, 20, 45);
    chk("run_entered", 32'(run_mode), 32'(1));
    press(1, 20, 20);
    chk("run_left", 32'(run_mode), 32'(0));

    // Run with run_div=0, then 5, then lowered below the current count.
    run_div = 8'd0;
    press(1, 20, 10);
    run_div = 8'd5;  ticks(20);
    run_div = 8'd7;  ticks($urandom_range(9, 4));
    run_div = 8'd1;  ticks(8);

    // Load edge lands on the same cycle as the mode key press.
    keys_n[1] = 1'b0; ticks(17);
    load_req  = 1'b1; ticks(10);
    keys_n[1] = 1'b1; ticks(25);
    chk("after_load_cnt", 32'(step_cnt), 32'(0));
    chk("after_load_mode", 32'(run_mode), 32'(0));
    load_req = 1'b0; ticks(5);

    // Random activity.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(39, 0) == 0) keys_n[$urandom_range(N - 1, 0)] ^= 1'b1;
      if ($urandom_range(49, 0) == 0) run_div = 8'($urandom_range(7, 0));
      if ($urandom_range(59, 0) == 0) load_req = ~load_req;
      tick();
    end
    keys_n = '1; load_req = 1'b0;
    ticks(25);

    // Reset mid-RUN just before a due pulse, with key 0 held through reset.
    run_div = 8'd2;
    if (!run_mode) press(1, 20, 0);
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (m_mode == 1 && m_div == 1) found = 1;
      else tick();
    end
    chk("wait_div", 32'(found), 32'(1));
    keys_n[0] = 1'b0;
    SYS_rst = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_ce", 32'(cpu_ce), 32'(0));
    ticks(3);
    SYS_rst = 1'b1;
    ticks(1);
    chk("rst_mode", 32'(run_mode), 32'(0));
    ticks(25);
    keys_n[0] = 1'b1;
    ticks(25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/board_step_ctrl.md
BOARD_STEP_CTRL -- requirements
Module: board_step_ctrl

Interface
REQ-001 Parameter N_KEYS, default 4 (min 2): number of board push-buttons handled.
REQ-002 Parameter DEB_CYCLES, default 16 (min 2): consecutive stable cycles required to accept a key change.
REQ-003 Parameter DIV_W, default 26: width of the run-mode divider.
REQ-004 Parameter CNT_W, default 16: width of the executed-step counter.
REQ-005 SYS_clk  input  1  single clock; all state on its rising edge.
REQ-006 SYS_rst  input  1  asynchronous, active-low reset.
REQ-007 keys_n  input  N_KEYS  raw push-buttons, active-low, asynchronous to SYS_clk; bit 0 = step, bit 1 = mode toggle.
REQ-008 run_div  input  DIV_W  run-mode period minus one, in SYS_clk cycles.
REQ-009 load_req  input  1  PC-load request level from the board switch.
REQ-010 cpu_ce  output  1  one-cycle CPU clock-enable pulse.
REQ-011 pc_load  output  1  one-cycle PC-load strobe.
REQ-012 key_level  output  N_KEYS  debounced key state, 1 = pressed.
REQ-013 key_press  output  N_KEYS  one-cycle pulse per accepted press.
REQ-014 run_mode  output  1  1 while in RUN state.
REQ-015 step_cnt  output  CNT_W  count of cpu_ce pulses since last reset or load.

Function
REQ-016 Each keys_n bit SHALL pass through a 2-flop synchroniser before use.
REQ-017 Per key: counter SHALL increment each cycle the synchronised pressed state differs from key_level; it SHALL clear on any cycle the two agree.
REQ-018 key_level[i] SHALL toggle, and its counter clear, on the DEB_CYCLES-th consecutive differing cycle; raw edge to key_level latency = 2 + DEB_CYCLES cycles.
REQ-019 Glitches shorter than DEB_CYCLES cycles SHALL NOT change key_level.
REQ-020 key_press[i] SHALL be high exactly the one cycle after key_level[i] rises; releases produce no pulse.
REQ-021 FSM states: STEP, RUN, LOAD; run_mode = (state == RUN).
REQ-022 STEP: key_press[0] SHALL produce cpu_ce high for exactly the next cycle; key_press[1] SHALL move to RUN.
REQ-023 STEP, key_press[0] and key_press[1] in the same cycle: mode change wins, no cpu_ce.
REQ-024 RUN: divider counter SHALL count 0,1,...; when counter >= run_div, cpu_ce SHALL be high that cycle and the counter SHALL wrap to 0; run_div = 0 gives cpu_ce every cycle.
REQ-025 RUN: lowering run_div below the current count SHALL cause a pulse and wrap on the next cycle, with no counter overflow.
REQ-026 RUN: key_press[1] SHALL move to STEP with cpu_ce low that cycle and the divider cleared; key_press[0] SHALL be ignored.
REQ-027 A rising edge of load_req (registered, synchronised) in STEP or RUN SHALL move to LOAD, with priority over any same-cycle key_press.
REQ-028 LOAD SHALL last exactly one cycle: pc_load = 1, cpu_ce = 0; next state is always STEP.
REQ-029 A held load_req level SHALL NOT retrigger; only a new rising edge does.
REQ-030 step_cnt SHALL increment by 1 on each cpu_ce cycle, wrap modulo 2^CNT_W, and clear to 0 in the pc_load cycle.
REQ-031 cpu_ce and pc_load SHALL never be high in the same cycle.

Reset
REQ-032 While SYS_rst = 0: state = STEP, all counters = 0, synchronisers = released, cpu_ce = pc_load = run_mode = 0, key_level = key_press = 0, step_cnt = 0.
REQ-033 Reset asserted mid-RUN or mid-LOAD SHALL abort immediately with no trailing cpu_ce or pc_load pulse.
REQ-034 After reset release, a key already held down SHALL be accepted as a press after 2 + DEB_CYCLES cycles.

Verification
REQ-035 DEB_CYCLES=16: keys_n[0] low for 10 cycles, then stable low -> no change for the glitch; key_level[0]=1 18 cycles after the stable edge; key_press[0] 1 cycle later; cpu_ce 1 cycle after that; step_cnt=1.
REQ-036 Press key1, run_div=3 -> run_mode=1, cpu_ce every 4th cycle; after 10 pulses step_cnt=10; press key1 -> run_mode=0, no further cpu_ce.
REQ-037 RUN, run_div=0 -> cpu_ce high every cycle; run_div changed 0->5 -> period 6 from the next wrap.
REQ-038 RUN with step_cnt=7, raise load_req in the same cycle as key_press[1] -> one pc_load cycle, cpu_ce=0, step_cnt=0, state STEP; held load_req gives no second pc_load.
REQ-039 CNT_W=4: 16 step presses -> step_cnt wraps 15->0.
REQ-040 Assert SYS_rst during RUN with a pulse due next cycle -> all outputs 0 immediately, no cpu_ce; after release, state is STEP.
